// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and default timing constants for the
// pixel-counter SRAM initiator.
//   - op_e     : request opcode (2'b11 decodes to OP_READ)
//   - state_e  : controller FSM state, also exported on dbg_state
//   - *_DEF    : default widths and cycle counts (2 ns clock)
package sram_ctrl_pkg;

    localparam int ADDR_BITS_DEF = 6;
    localparam int DATA_BITS_DEF = 12;
    localparam int PULSE_CYC_DEF = 4;
    localparam int PRECH_CYC_DEF = 4;
    localparam int TO_CYC_DEF    = 8;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_INCR  = 2'b10
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_PRECH  = 3'd3,
        ST_WSETUP = 3'd4
    } state_e;

    // The unused encoding 2'b11 behaves as a READ.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'b01:   decode_op = OP_WRITE;
            2'b10:   decode_op = OP_INCR;
            default: decode_op = OP_READ;
        endcase
    endfunction

endpackage

// File: rtl/sram_ctrl_cyc_timer.sv
// sram_ctrl_cyc_timer: loadable down-counter with a zero flag. Counts down
// by one per cycle and rests at zero; a load takes priority.
//   clk, rst  : clock, asynchronous active-high reset (count <= RST_VAL)
//   load      : load load_val this cycle
//   load_val  : value to load
//   count     : current count
//   zero      : count == 0
module sram_ctrl_cyc_timer
    import sram_ctrl_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: initiator for the 64x12 pixel-counter SRAM. Accepts READ, WRITE
// and saturating INCR requests and sequences the SRAM's asynchronous strobes
// with a setup cycle, a minimum strobe width, done/timeout handling and a
// precharge gap.
//   req_valid/req_ready : request handshake. A request transfers on a rising
//                         clk edge where both are high; req_ready is high
//                         only in IDLE and the request fields are latched
//                         on that edge. req_valid may stay high to queue the
//                         next request.
//   req_op/addr/wdata   : opcode, word address, write data
//   rsp_valid/rsp_rdata : one-cycle pulse with read data (READ, INCR)
//   err                 : sticky done-timeout flag
//   sram_*              : SRAM strobes, address, data and done flags
//   dbg_state           : current FSM state (state_e encoding)
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF,
    parameter int PRECH_CYC = PRECH_CYC_DEF,
    parameter int TO_CYC    = TO_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 err,
    output logic                 sram_read,
    output logic                 sram_write,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [DATA_BITS-1:0] sram_din,
    input  logic [DATA_BITS-1:0] sram_dout,
    input  logic                 sram_read_done,
    input  logic                 sram_write_done,
    output logic [2:0]           dbg_state
);

    localparam int TW = $clog2(PULSE_CYC + TO_CYC + PRECH_CYC + 1);
    // ACTIVE loads the whole pulse+timeout budget; the minimum width is met
    // once the count has fallen to TO_CYC. PRECH counts down to zero.
    localparam logic [TW-1:0] ACT_LOAD = TW'(PULSE_CYC + TO_CYC - 1);
    localparam logic [TW-1:0] MIN_LEFT = TW'(TO_CYC);
    localparam logic [TW-1:0] PRE_LOAD = TW'(PRECH_CYC - 1);

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   din_q, din_d;
    logic [DATA_BITS-1:0]   rdata_q, rdata_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic                   rsp_pend_q, rsp_pend_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   err_q, err_d;
    logic                   incr_wr_q, incr_wr_d;   // INCR read done, write phase next

    logic                   tmr_load;
    logic [TW-1:0]          tmr_val;
    logic [TW-1:0]          tmr_count;
    logic                   tmr_zero;
    logic                   done_sel;
    logic                   pulse_ok;

    sram_ctrl_cyc_timer #(
        .WIDTH   (TW),
        .RST_VAL (PRE_LOAD)
    ) u_cyc_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rdata_d     = rdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        rsp_pend_d  = 1'b0;
        rsp_valid_d = rsp_pend_q;   // response follows the strobe fall by one cycle
        err_d       = err_q;
        incr_wr_d   = incr_wr_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        done_sel    = rd_q ? sram_read_done : sram_write_done;
        pulse_ok    = (tmr_count <= MIN_LEFT);

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = decode_op(req_op);
                    addr_d  = req_addr;
                    din_d   = req_wdata;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d  = ST_ACTIVE;
                tmr_load = 1'b1;
                tmr_val  = ACT_LOAD;
                if (op_q == OP_WRITE) begin
                    wr_d = 1'b1;
                end else begin
                    rd_d = 1'b1;
                end
            end
            ST_WSETUP: begin
                state_d  = ST_ACTIVE;
                tmr_load = 1'b1;
                tmr_val  = ACT_LOAD;
                wr_d     = 1'b1;
            end
            ST_ACTIVE: begin
                // At count zero pulse_ok is also true, so !done_sel here
                // means the timeout expired.
                if ((pulse_ok && done_sel) || tmr_zero) begin
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    state_d  = ST_PRECH;
                    tmr_load = 1'b1;
                    tmr_val  = PRE_LOAD;
                    if (!done_sel) begin
                        err_d = 1'b1;
                    end
                    if (rd_q) begin
                        rdata_d    = sram_dout;
                        rsp_pend_d = 1'b1;
                    end
                    incr_wr_d = rd_q && (op_q == OP_INCR) && done_sel;
                end
            end
            ST_PRECH: begin
                if (tmr_zero) begin
                    if (incr_wr_q) begin
                        state_d   = ST_WSETUP;
                        incr_wr_d = 1'b0;
                        din_d     = (&rdata_q) ? rdata_q : rdata_q + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d  = ST_PRECH;
                tmr_load = 1'b1;
                tmr_val  = PRE_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PRECH;
            op_q        <= OP_READ;
            addr_q      <= '0;
            din_q       <= '0;
            rdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_pend_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            incr_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rdata_q     <= rdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            incr_wr_q   <= incr_wr_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign err        = err_q;
    assign sram_read  = rd_q;
    assign sram_write = wr_q;
    assign sram_addr  = addr_q;
    assign sram_din   = din_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: bench for sram_ctrl with a behavioural 64x12 SRAM, a strobe
// protocol monitor and a response scoreboard.
module tb_sram_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 12;
    localparam int PULSE = 4;
    localparam int PRECH = 4;
    localparam int TO    = 8;

    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] IN = 2'b10;
    localparam logic [1:0] RX = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op    = 2'b00;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          err;
    logic          sram_read, sram_write;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout = '0;
    logic          rd_done   = 1'b0;
    logic          wr_done   = 1'b0;
    logic [2:0]    dbg_state;

    sram_ctrl #(
        .ADDR_BITS (AW),
        .DATA_BITS (DW),
        .PULSE_CYC (PULSE),
        .PRECH_CYC (PRECH),
        .TO_CYC    (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .err             (err),
        .sram_read       (sram_read),
        .sram_write      (sram_write),
        .sram_addr       (sram_addr),
        .sram_din        (sram_din),
        .sram_dout       (sram_dout),
        .sram_read_done  (rd_done),
        .sram_write_done (wr_done),
        .dbg_state       (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM model ----------------
    logic [DW-1:0] mem [64];
    logic          stall_rd = 1'b0;

    always @(posedge clk) begin
        rd_done <= sram_read && !stall_rd;
        wr_done <= sram_write;
        if (sram_read)  sram_dout <= mem[sram_addr];
        if (sram_write) mem[sram_addr] <= sram_din;
    end

    // ---------------- strobe protocol monitor ----------------
    logic          rd_prev = 1'b0, wr_prev = 1'b0;
    logic [AW-1:0] addr_prev = '0;
    logic [DW-1:0] din_prev = '0;
    int            hi_cnt = 0, lo_cnt = 0, last_width = 0;
    logic          have_fall = 1'b0;
    time           t_wr_fall = 0;

    always @(negedge sram_write) t_wr_fall = $time;

    always @(negedge clk) begin
        if (rst) begin
            hi_cnt    = 0;
            lo_cnt    = 0;
            have_fall = 1'b0;
        end else begin
            if (sram_read || sram_write) begin
                chk("rd_wr_exclusive", {31'd0, sram_read & sram_write}, 32'd0);
            end
            if ((sram_read || sram_write) && (rd_prev || wr_prev)) begin
                chk("addr_stable", {26'd0, sram_addr}, {26'd0, addr_prev});
                chk("din_stable", {20'd0, sram_din}, {20'd0, din_prev});
                hi_cnt++;
            end else if (sram_read || sram_write) begin
                if (have_fall) chk("prech_gap_ge5", {31'd0, lo_cnt >= PRECH + 1}, 32'd1);
                hi_cnt = 1;
            end else if (rd_prev || wr_prev) begin
                last_width = hi_cnt;
                chk("strobe_width_ge4", {31'd0, hi_cnt >= PULSE}, 32'd1);
                have_fall = 1'b1;
                lo_cnt    = 1;
            end else begin
                lo_cnt++;
            end
        end
        rd_prev   = sram_read;
        wr_prev   = sram_write;
        addr_prev = sram_addr;
        din_prev  = sram_din;
    end

    // ---------------- response scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic          rsp_prev = 1'b0;
    int            rsp_count = 0;
    int            last_rsp_cyc = 0;

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            chk("rsp_single_pulse", {31'd0, rsp_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rdata %0h with empty queue", rsp_rdata);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                chk("rsp_rdata", {20'd0, rsp_rdata}, {20'd0, e});
            end
            last_rsp_cyc = cyc;
            rsp_count++;
        end
        rsp_prev = rsp_valid;
    end

    // ---------------- driver tasks ----------------
    int acc_cyc = 0;

    // Leaves req_valid high on return so the next call is accepted on the
    // first IDLE cycle; callers drop it when the burst ends.
    task automatic drive_one(input logic [1:0] op, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic has_rsp,
                             input logic [DW-1:0] exp, output int lat);
        int w;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        if (has_rsp) exp_q.push_back(exp);
        w = 0;
        while (!req_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!req_ready) chk("accept_wait", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        lat = 0;
        while (!req_ready && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_reset();
        int w;
        @(negedge clk);
        rst = 1'b0;
        w = 0;
        while (w < 50) begin
            @(posedge clk); #1;
            w++;
            if (req_ready) break;
            chk("no_strobe_in_prech", {30'd0, sram_read, sram_write}, 32'd0);
        end
        chk("ready_after_reset", w, 4);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          has_rsp;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int lat;
        int n0;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        time t_rst;

        vecs[0]  = '{WR, 6'h05, 12'hA5C, 1'b0, 12'h000, 9};
        vecs[1]  = '{RD, 6'h05, 12'h000, 1'b1, 12'hA5C, 9};
        vecs[2]  = '{WR, 6'h3F, 12'hFFE, 1'b0, 12'h000, 9};
        vecs[3]  = '{IN, 6'h3F, 12'h000, 1'b1, 12'hFFE, 18};
        vecs[4]  = '{IN, 6'h3F, 12'h000, 1'b1, 12'hFFF, 18};
        vecs[5]  = '{IN, 6'h3F, 12'h000, 1'b1, 12'hFFF, 18};
        vecs[6]  = '{RD, 6'h3F, 12'h000, 1'b1, 12'hFFF, 9};
        vecs[7]  = '{WR, 6'h10, 12'h7FF, 1'b0, 12'h000, 9};
        vecs[8]  = '{IN, 6'h10, 12'h000, 1'b1, 12'h7FF, 18};
        vecs[9]  = '{RD, 6'h10, 12'h000, 1'b1, 12'h800, 9};
        vecs[10] = '{RX, 6'h10, 12'h000, 1'b1, 12'h800, 9};
        vecs[11] = '{IN, 6'h00, 12'h000, 1'b1, 12'h000, 18};
        vecs[12] = '{RD, 6'h00, 12'h000, 1'b1, 12'h001, 9};

        for (int i = 0; i < 64; i++) mem[i] = '0;

        // reset state
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {20'd0, rsp_rdata}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_strobes", {30'd0, sram_read, sram_write}, 32'd0);
        chk("rst_sram_addr", {26'd0, sram_addr}, 32'd0);
        chk("rst_sram_din", {20'd0, sram_din}, 32'd0);
        release_reset();

        // table: req_valid held high across all vectors
        for (int i = 0; i < 13; i++) begin
            drive_one(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].has_rsp,
                      vecs[i].exp_rdata, lat);
            chk($sformatf("lat_v%0d", i), lat, vecs[i].exp_lat);
            if (vecs[i].has_rsp) chk($sformatf("rsp_cyc_v%0d", i), last_rsp_cyc - acc_cyc, PULSE + 2);
        end
        req_valid = 1'b0;
        chk("mem_3f_final", {20'd0, mem[6'h3F]}, 32'hFFF);
        chk("err_clear", {31'd0, err}, 32'd0);

        // random write/read pairs
        for (int k = 0; k < 4; k++) begin
            ra = 6'($urandom_range(32, 62));
            rd = 12'($urandom_range(0, 4095));
            drive_one(WR, ra, rd, 1'b0, 12'h000, lat);
            chk("rand_wr_lat", lat, 9);
            drive_one(RD, ra, 12'h000, 1'b1, rd, lat);
            chk("rand_rd_lat", lat, 9);
        end
        req_valid = 1'b0;

        // read done never arrives: timeout on READ, then on INCR (write aborted)
        repeat (2) @(posedge clk); #1;
        stall_rd = 1'b1;
        n0 = rsp_count;
        drive_one(RD, 6'h05, 12'h000, 1'b1, 12'hA5C, lat);
        req_valid = 1'b0;
        chk("to_rd_width", last_width, PULSE + TO);
        chk("to_rd_err", {31'd0, err}, 32'd1);
        chk("to_rd_rsp", rsp_count - n0, 1);
        chk("to_rd_lat", lat, 1 + PULSE + TO + PRECH);
        drive_one(IN, 6'h10, 12'h000, 1'b1, 12'h800, lat);
        req_valid = 1'b0;
        chk("to_incr_lat", lat, 1 + PULSE + TO + PRECH);
        stall_rd = 1'b0;
        drive_one(RD, 6'h10, 12'h000, 1'b1, 12'h800, lat);
        req_valid = 1'b0;
        chk("after_to_lat", lat, 9);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // reset during an active write
        drive_one(WR, 6'h2A, 12'h5A5, 1'b0, 12'h000, lat);
        req_valid = 1'b0;
        drive_one(WR, 6'h2B, 12'h3C3, 1'b0, 12'h000, lat);
        req_valid = 1'b0;
        drive_one(WR, 6'h2C, 12'h111, 1'b0, 12'h000, lat);
        req_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = WR;
        req_addr  = 6'h2D;
        req_wdata = 12'h777;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_wr_high", {31'd0, sram_write}, 32'd1);
        rst   = 1'b1;
        t_rst = $time;
        #1;
        chk("mid_wr_fall_same_step", 32'(t_wr_fall), 32'(t_rst));
        chk("mid_wr_low", {31'd0, sram_write}, 32'd0);
        chk("mid_addr_clr", {26'd0, sram_addr}, 32'd0);
        chk("mid_err_clr", {31'd0, err}, 32'd0);
        repeat (2) @(posedge clk);
        release_reset();

        drive_one(RD, 6'h05, 12'h000, 1'b1, 12'hA5C, lat);
        req_valid = 1'b0;
        chk("post_rst_lat", lat, 9);

        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous initiator for the 64x12 pixel-counter SRAM. It accepts READ, WRITE and saturating-INCR requests from the counting logic over a valid/ready port and drives the SRAM's asynchronous read/write strobes. It enforces the SRAM's access rules: minimum strobe width, minimum precharge gap, a stable address and data window, and no simultaneous read and write. Completed reads and INCRs return data on a one-cycle response pulse.

## Interface
- ADDR_BITS, 6, SRAM address width
- DATA_BITS, 12, SRAM data width
- PULSE_CYC, 4, minimum strobe-high cycles; must be ≥ ceil(8 ns / Tclk); default assumes 2 ns clock
- PRECH_CYC, 4, minimum strobe-low cycles between accesses; must be ≥ ceil(8 ns / Tclk)
- TO_CYC, 8, extra cycles to wait for done before flagging an error
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  2  2'b00 READ, 2'b01 WRITE, 2'b10 INCR; 2'b11 treated as READ
- req_addr  in  ADDR_BITS  target word
- req_wdata  in  DATA_BITS  write data (WRITE only)
- rsp_valid  out  1  one-cycle pulse with read data (READ, INCR)
- rsp_rdata  out  DATA_BITS  data read; for INCR, the pre-increment value
- err  out  1  sticky done-timeout flag
- sram_read, sram_write  out  1 each  SRAM strobes, active-high
- sram_addr  out  ADDR_BITS  SRAM address
- sram_din  out  DATA_BITS  SRAM write data
- sram_dout  in  DATA_BITS  SRAM read data
- sram_read_done, sram_write_done  in  1 each  SRAM completion flags, sampled directly on clk with no synchronizer

## Operation
- FSM states:
  - IDLE
  - SETUP: address and data driven, strobes low, 1 cycle
  - ACTIVE: one strobe high
  - PRECH: strobes low, address held
  - WSETUP: INCR write phase, 1 cycle
- Accept: in IDLE, req_ready=1. The accept edge latches op, addr and wdata, then goes to SETUP. sram_addr and sram_din update only at the accept edge or at WSETUP entry.
- SETUP → ACTIVE: asserts sram_read (READ, INCR) or sram_write (WRITE).
- ACTIVE exit: after ≥PULSE_CYC cycles and the matching done sampled high, drop the strobe and go to PRECH.
  - On a read phase, capture sram_dout into rsp_rdata on the last ACTIVE edge.
- PRECH lasts PRECH_CYC cycles, then:
  - IDLE, or
  - WSETUP if this was the INCR read phase.
- INCR write value: sram_din = (old == all-ones) ? old : old+1, in DATA_BITS unsigned arithmetic. WSETUP → ACTIVE(write) → PRECH → IDLE.
- rsp_valid: pulses the cycle after the read-phase strobe falls, for both READ and INCR.
- Timeout: if done is not seen within PULSE_CYC+TO_CYC ACTIVE cycles:
  - drop the strobe and set err;
  - a READ still pulses rsp_valid with the captured value;
  - an INCR aborts its write phase.
  - err clears only on rst.
- sram_read and sram_write are never high together, by construction.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, err=0, sram_read=0, sram_write=0, sram_addr=0, sram_din=0. State=PRECH with a full PRECH_CYC count.
- After rst falls, req_ready rises after PRECH_CYC cycles. This guarantees precharge before the first access.
- Reset mid-access: the strobe drops asynchronously and sram_addr clears. The SRAM model may report an address change while done is still high; this is accepted.
- Cycles from accept edge to req_ready high, with done arriving in time:
  - READ/WRITE: 1+PULSE_CYC+PRECH_CYC
  - INCR: 2·(1+PULSE_CYC+PRECH_CYC)
- READ rsp_valid arrives PULSE_CYC+2 cycles after the accept edge.
- Back-to-back requests: the strobe-low gap is ≥PRECH_CYC+1 cycles. req_valid held high is accepted again on the first IDLE cycle.

## Structure
- sram_ctrl_pkg:
  - op encoding enum (OP_READ, OP_WRITE, OP_INCR)
  - FSM state enum
  - default cycle constants
- One sub-module, cyc_timer: a loadable down-counter with a zero flag. It is shared by the ACTIVE, PRECH and timeout counting.

## Test plan
- Reset release, defaults → req_ready low exactly 4 cycles after rst falls, then high. No SRAM strobes during that time.
- WRITE addr 6'h05, data 12'hA5C, then READ 6'h05:
  - sram_write is high ≥4 cycles;
  - sram_addr and sram_din are stable throughout;
  - rsp_valid pulses once with 12'hA5C;
  - no model ERROR lines.
- Preload 6'h3F=12'hFFE, then INCR three times:
  - rsp_rdata returns FFE, FFF, FFF;
  - final memory value is 12'hFFF.
- req_valid held high over 10 mixed ops → every gap between strobe fall and next strobe rise is ≥5 cycles; read and write are never high together.
- Stub holds sram_read_done at 0 → sram_read falls after 12 cycles, err=1, rsp_valid pulses, and the next request is still served.
- rst asserted during ACTIVE write → sram_write falls within the same timestep; req_ready returns 4 cycles after rst falls.
